// File: rtl/axi4lite_memory_slave.sv
`timescale 1ns/1ps
// AXI4-lite word-addressed RAM responder with programmable read/write latency.
// Independent read and write FSMs, one outstanding transaction per direction.
module axi4lite_memory_slave #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Misaligned or beyond the RAM footprint.
  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || (|a[ADDR_WIDTH-1:IDX_W+2]);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Read channel state
  r_state_t              r_state, r_state_d;
  logic [CNT_W-1:0]      r_cnt, r_cnt_d;
  logic [IDX_W-1:0]      r_idx, r_idx_d;
  logic                  r_err, r_err_d;
  logic                  arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [1:0]            rresp_d;

  // Write channel state
  w_state_t              w_state, w_state_d;
  logic [CNT_W-1:0]      w_cnt, w_cnt_d;
  logic                  aw_held, aw_held_d, w_held, w_held_d;
  logic [IDX_W-1:0]      w_idx, w_idx_d;
  logic                  w_err, w_err_d;
  logic [DATA_WIDTH-1:0] w_data, w_data_d;
  logic [STRB_W-1:0]     w_strb, w_strb_d;
  logic                  awready_d, wready_d, bvalid_d;
  logic [1:0]            bresp_d;
  logic                  mem_we;
  logic                  aw_hs, w_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
      w_state <= W_IDLE;
      w_cnt   <= '0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_idx   <= '0;
      w_err   <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      r_state <= r_state_d;
      r_cnt   <= r_cnt_d;
      r_idx   <= r_idx_d;
      r_err   <= r_err_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
      w_state <= w_state_d;
      w_cnt   <= w_cnt_d;
      aw_held <= aw_held_d;
      w_held  <= w_held_d;
      w_idx   <= w_idx_d;
      w_err   <= w_err_d;
      w_data  <= w_data_d;
      w_strb  <= w_strb_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bresp   <= bresp_d;
    end
  end

  // Read FSM: sample RAM on the last latency cycle so rvalid rises READ_LATENCY after AR.
  always_comb begin
    r_state_d = r_state;
    r_cnt_d   = r_cnt;
    r_idx_d   = r_idx;
    r_err_d   = r_err;
    arready_d = arready;
    rvalid_d  = rvalid;
    rdata_d   = rdata;
    rresp_d   = rresp;
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_state_d = R_WAIT;
          r_cnt_d   = CNT_W'(READ_LATENCY - 1);
          r_idx_d   = araddr[IDX_W+1:2];
          r_err_d   = addr_err(araddr);
          arready_d = 1'b0;
        end
      end
      R_WAIT: begin
        if (r_cnt == '0) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          rdata_d   = r_err ? '0 : mem[r_idx];
          rresp_d   = r_err ? SLVERR : OKAY;
        end else begin
          r_cnt_d = r_cnt - 1'b1;
        end
      end
      R_RESP: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: AW and W latch independently; latency starts once both are held.
  always_comb begin
    w_state_d = w_state;
    w_cnt_d   = w_cnt;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    w_idx_d   = w_idx;
    w_err_d   = w_err;
    w_data_d  = w_data;
    w_strb_d  = w_strb;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    bresp_d   = bresp;
    mem_we    = 1'b0;
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          w_idx_d   = awaddr[IDX_W+1:2];
          w_err_d   = addr_err(awaddr);
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
          wready_d = 1'b0;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          w_state_d = W_WAIT;
          w_cnt_d   = CNT_W'(WRITE_LATENCY - 1);
        end
      end
      W_WAIT: begin
        if (w_cnt == '0) begin
          w_state_d = W_RESP;
          mem_we    = !w_err;
          bvalid_d  = 1'b1;
          bresp_d   = w_err ? SLVERR : OKAY;
        end else begin
          w_cnt_d = w_cnt - 1'b1;
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // RAM commit; gated by reset so an interrupted write never lands. Same-edge reads see old data.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/axi4lite_memory_slave.md
Name: axi4lite_memory_slave

Overview:
- Clocked AXI4-lite responder: a word-addressed RAM that serves the cache's refill reads and write-backs on the memory side of the cache.
- Adds programmable read and write latency so the cache controller's wait states, stalls and back-pressure paths get exercised.
- Read and write channels run independent state machines; one outstanding transaction per direction.

Parameters:
- ADDR_WIDTH, 32, byte-address width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte strobes).
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two.
- READ_LATENCY, 2, cycles from AR handshake to RVALID rise; legal range 1..15.
- WRITE_LATENCY, 2, cycles from both AW and W captured to BVALID rise; legal range 1..15.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- awaddr  input  ADDR_WIDTH  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- wdata  input  32  write data
- wstrb  input  4  byte write strobes; bit i enables wdata[8i+7:8i]
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- araddr  input  ADDR_WIDTH  read address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- rdata  output  32  read data
- rresp  output  2  read response: OKAY / SLVERR
- rvalid  output  1  read data valid
- rready  input  1  read data ready

Behaviour:
- Reset (sync, active-high):
  - Outputs: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, rdata=0, bresp=0, rresp=0.
  - Both FSMs go to IDLE; latency counters clear.
  - RAM contents are not reset.
- Reset mid-transaction:
  - The pending transaction is dropped; bvalid/rvalid are low the cycle after reset.
  - A write still in W_WAIT is never committed.
- Address decode:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - SLVERR if addr[1:0]!=0 or addr >= 4*DEPTH_WORDS.
  - An SLVERR write does not modify the RAM. An SLVERR read returns rdata=0.
- Read FSM (R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: arready=1. When arvalid&arready, capture araddr, load counter = READ_LATENCY-1, go to R_WAIT. arready drops next cycle.
  - R_WAIT: arready=0. Decrement the counter. At 0, sample RAM/decode into rdata/rresp and go to R_RESP. rvalid rises exactly READ_LATENCY cycles after the handshake edge.
  - R_RESP: rvalid=1; rdata/rresp held stable until rvalid&rready. On that handshake, go to R_IDLE with rvalid=0 and arready=1 the next cycle.
  - No new AR is accepted before the R handshake.
- Write FSM (W_IDLE, W_WAIT, W_RESP):
  - W_IDLE: AW and W are captured independently. awready drops after the AW handshake; wready drops after the W handshake.
  - AW and W may arrive in the same cycle or in either order. Once both are held, load counter = WRITE_LATENCY-1 and go to W_WAIT.
  - W_WAIT: decrement the counter. At 0, commit wdata under wstrb (strobe-cleared bytes unchanged), set bresp, go to W_RESP.
  - W_RESP: bvalid=1; bresp held until bvalid&bready. Then go to W_IDLE with awready=wready=1 the next cycle.
- Read/write collision:
  - Channels are fully concurrent.
  - If a write commit and a read sample hit the same word in the same cycle, the read returns the pre-write data.
  - A read sampled any later cycle sees the new data.
- Back-pressure: rready/bready may stay low indefinitely; outputs are held, nothing is lost or duplicated.
- wstrb=4'b0000 with a valid address: OKAY response, RAM unchanged.

Test Plan:
- Write 0xDEADBEEF to 0x10 (wstrb=F), then read 0x10 -> bresp=00; rvalid exactly 2 cycles after AR handshake; rdata=0xDEADBEEF, rresp=00.
- W presented 3 cycles before AW (addr 0x20, data 0x11223344) -> wready drops after W handshake; bvalid 2 cycles after AW capture; read 0x20 returns 0x11223344.
- Partial strobe: 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb=4'b0101 -> read 0x20 returns 0x11BB33DD.
- Errors: read 0x1002 (misaligned) -> rresp=10, rdata=0; write 0x1000 (DEPTH_WORDS=1024) -> bresp=10; read 0x0FFC unchanged.
- Back-pressure: hold rready=0 for 10 cycles -> rvalid, rdata and rresp stable throughout; arready=0 until the R handshake.
- Assert reset during W_WAIT of a write of 0x55 to 0x30 (0x30 previously 0x0) -> bvalid=0 after reset; a subsequent read of 0x30 returns 0x0.
